serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder: latches two operands on a `start` pulse and adds them LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop. It presents a registered sum and carry-out with a one-cycle `done` strobe. It is the additive counterpart of the team's half-subtractor arithmetic blocks. It serves as the low-area arithmetic primitive for sequential datapaths where throughput is not critical.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when the block is not busy.
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `busy`  output  1  high while an addition is in progress.
- `done`  output  1  one-cycle strobe; `sum`, `carry` (and `ovf`) are valid from this cycle onward.
- `sum`  output  WIDTH  result `a+b` mod 2^WIDTH; held until the next `done`.
- `carry`  output  1  unsigned carry-out of bit WIDTH-1; held until the next `done`.
- `ovf`  output  1  signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: one bit processed per cycle.
  - DONE: one-cycle completion state.
- Internal registers: operand shift registers `ra`, `rb` (WIDTH each), accumulator `racc` (WIDTH), carry flip-flop `c`, bit counter `cnt` (clog2(WIDTH) bits).
- IDLE, `start=1`:
  - load `ra=a`, `rb=b`, `c=0`, `cnt=0`, `racc=0`;
  - move to SHIFT.
- SHIFT, each cycle:
  - `s = ra[0]^rb[0]^c`;
  - `c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0]))`;
  - `racc <= {s, racc[WIDTH-1:1]}`;
  - `ra`, `rb` shift right with zero fill;
  - `cnt` increments.
- SHIFT, on the cycle where `cnt==WIDTH-1`:
  - `sum <= {s, racc[WIDTH-1:1]}`;
  - `carry <=` next carry;
  - move to DONE.
- DONE, `start=1`: accepted exactly as in IDLE (back-to-back operation), then move to SHIFT.
- DONE, `start=0`: move to IDLE.
- `start` asserted in SHIFT is ignored. It is not queued.
- Changes to `a` and `b` after the accepting edge have no effect.
- `busy = (state==SHIFT)`; `done = (state==DONE)`. Both are decoded from registered state, so they are glitch-free.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `busy=0`, `done=0`, `sum=0`, `carry=0`, `ovf=0`, all internal registers 0.
- Reset asserted mid-SHIFT aborts the operation. No `done` is issued and the previous `sum` is lost (cleared to 0).
- Accept edge T0: `busy=1` after T0.
- Bits 0..WIDTH-1 are processed at edges T0+1 .. T0+WIDTH.
- At T0+WIDTH: `busy=0`, `done=1` for exactly one cycle, outputs updated.
- Latency from the accepting edge to `done` is WIDTH cycles. Minimum issue interval is WIDTH+1 cycles when `start` is held high.
- `sum` and `carry` change only on the edge that raises `done`.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - port `ovf` exists;
  - at completion `ovf <= (a[WIDTH-1]==b[WIDTH-1]) && (s_msb != a[WIDTH-1])`, using the latched operand MSBs (an extra 2-bit register);
  - `ovf` is held and reset like `sum`.
- Not defined: no `ovf` port, no MSB capture registers. All other behaviour is identical.

## Test plan
- Reset, then `a=8'h00`, `b=8'h00`, start → `done` 8 cycles later; `sum=00`, `carry=0`, `ovf=0`.
- `a=8'hFF`, `b=8'h01` → `sum=00`, `carry=1`, `ovf=0`.
- `a=8'h7F`, `b=8'h01` → `sum=80`, `carry=0`, `ovf=1` (macro on); no `ovf` port with the macro off.
- Start `3C+05`, pulse `start` with `a=FF` at cycle 3 while busy → single `done`, `sum=41`, `carry=0`.
- Start `A5+5A`, assert `rst_n=0` at cycle 4 → outputs 0 immediately, no `done`. Then `12+34` after release → `sum=46`.
- Hold `start=1` with `01+01`, then `80+80` presented at the DONE cycle → `sum=02`, then `sum=00` with `carry=1`; `done` pulses 9 cycles apart.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop, LSB first, WIDTH cycles per add.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             carry,
  output logic             ovf
`else
  output logic             carry
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] ra, rb, racc;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s, cn;
  logic             accept, last;

`ifdef SERIAL_ADDER_OVF_EN
  logic am, bm;
`endif

  // A request is honoured in IDLE and in DONE (back-to-back); ignored while shifting.
  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign s  = ra[0] ^ rb[0] ^ c;
  assign cn = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      racc  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      am    <= 1'b0;
      bm    <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      ra   <= a;
      rb   <= b;
      racc <= '0;
      cnt  <= '0;
      c    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      am   <= a[WIDTH-1];
      bm   <= b[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      c    <= cn;
      racc <= {s, racc[WIDTH-1:1]};
      ra   <= ra >> 1;
      rb   <= rb >> 1;
      cnt  <= cnt + CW'(1);
      // Outputs are only written on the final bit so they hold between completions.
      if (last) begin
        sum   <= {s, racc[WIDTH-1:1]};
        carry <= cn;
`ifdef SERIAL_ADDER_OVF_EN
        ovf   <= (am == bm) && (s != am);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a result scoreboard checked on each done strobe.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .carry (carry),
    .ovf   (ovf)
`else
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ndone = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected result computed arithmetically, independent of the serial datapath.
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y};
    e.s = full[W-1:0];
    e.c = full[W];
    e.o = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      ndone++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry", 32'(carry), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.o));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (sampled just after the edge), returning cycles taken; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    push_exp(x, y);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic add_and_check(input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    issue(x, y);
    wait_done(lat);
    chk("latency", 32'(lat), 32'(W));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lat, n0;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    add_and_check(8'h00, 8'h00);
    add_and_check(8'hFF, 8'h01);
    add_and_check(8'h7F, 8'h01);

    // start pulsed mid-operation with a new operand must be ignored
    issue(8'h3C, 8'h05);
    tick();
    a = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_during_ignored_start", 32'(busy), 32'd1);
    n0 = ndone;
    wait_done(lat);
    chk("latency_ignored_start", 32'(lat + 2), 32'(W));
    for (int i = 0; i < 12; i++) tick();
    chk("single_done", 32'(ndone - n0), 32'd1);
    chk("sum_held", 32'(sum), 32'h41);

    // reset mid-shift aborts and clears outputs immediately
    a = 8'hA5;
    b = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    n0 = ndone;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_done", 32'(ndone - n0), 32'd0);
    add_and_check(8'h12, 8'h34);

    // back-to-back with start held high
    issue(8'h01, 8'h01);
    start = 1'b1;
    wait_done(lat);
    chk("b2b_latency1", 32'(lat), 32'(W));
    push_exp(8'h80, 8'h80);
    a = 8'h80;
    b = 8'h80;
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("b2b_interval", 32'(lat + 1), 32'(W + 1));
    tick();
    tick();
    chk("b2b_sum", 32'(sum), 32'h00);
    chk("b2b_carry", 32'(carry), 32'd1);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
